tile_sched: RTL

TILE_SCHED -- requirements
Module: tile_sched

---
 rtl/tile_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tile_sched.sv
// tile_sched: frame-level scheduler walking tiles in raster order through clear, rasterize and write engines.
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   frame_start / frame_busy / frame_done   frame handshake (done is a one-cycle pulse)
//   vblank                           display vertical blank level, gates the buffer flip
//   fb_base_a, fb_base_b             qword base addresses of the two frame buffers
//   clr_start/clr_done, rast_start/rast_done, tw_start/tw_done   per-tile engine handshakes
//   tile_px, tile_py                 pixel origin of the current tile
//   tw_fb_base, disp_fb_base         draw buffer base and scan-out buffer base
// Build option: define TILE_SCHED_DBUF_EN for double buffering with a vblank-synchronised flip;
// without it both bases follow fb_base_a and vblank is unused.
module tile_sched #(
    parameter int TILES_X    = 20,
    parameter int TILES_Y    = 15,
    parameter int TILE_SHIFT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    output logic        frame_busy,
    output logic        frame_done,
    input  logic        vblank,
    input  logic [28:0] fb_base_a,
    input  logic [28:0] fb_base_b,
    output logic        clr_start,
    input  logic        clr_done,
    output logic        rast_start,
    input  logic        rast_done,
    output logic        tw_start,
    input  logic        tw_done,
    output logic [15:0] tile_px,
    output logic [15:0] tile_py,
    output logic [28:0] tw_fb_base,
    output logic [28:0] disp_fb_base
);
    typedef enum logic [3:0] {
        IDLE, CLEAR, CLEAR_WAIT, RAST, RAST_WAIT, WRITE, WRITE_WAIT, NEXT, FLIP_WAIT, DONE
    } state_t;

    localparam logic [15:0] X_LAST = 16'(TILES_X - 1);
    localparam logic [15:0] Y_LAST = 16'(TILES_Y - 1);

    state_t      state;
    logic [15:0] tx, ty;

`ifdef TILE_SCHED_DBUF_EN
    logic buf_sel;
`else
    logic unused_ok;
    assign unused_ok = ^{vblank, fb_base_b};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= '0;
            ty         <= '0;
            tile_px    <= '0;
            tile_py    <= '0;
            clr_start  <= 1'b0;
            rast_start <= 1'b0;
            tw_start   <= 1'b0;
            frame_done <= 1'b0;
            frame_busy <= 1'b0;
`ifdef TILE_SCHED_DBUF_EN
            buf_sel      <= 1'b0;
            tw_fb_base   <= fb_base_b;
            disp_fb_base <= fb_base_a;
`else
            tw_fb_base   <= fb_base_a;
            disp_fb_base <= fb_base_a;
`endif
        end else begin
            clr_start  <= 1'b0;
            rast_start <= 1'b0;
            tw_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: if (frame_start) begin
                    state      <= CLEAR;
                    clr_start  <= 1'b1;
                    frame_busy <= 1'b1;
                    tx         <= '0;
                    ty         <= '0;
                    tile_px    <= '0;
                    tile_py    <= '0;
                    // Bases are refreshed only between frames so a frame never sees them move.
`ifdef TILE_SCHED_DBUF_EN
                    tw_fb_base   <= buf_sel ? fb_base_a : fb_base_b;
                    disp_fb_base <= buf_sel ? fb_base_b : fb_base_a;
`else
                    tw_fb_base   <= fb_base_a;
                    disp_fb_base <= fb_base_a;
`endif
                end
                CLEAR:      state <= CLEAR_WAIT;
                CLEAR_WAIT: if (clr_done) begin
                    state      <= RAST;
                    rast_start <= 1'b1;
                end
                RAST:       state <= RAST_WAIT;
                RAST_WAIT:  if (rast_done) begin
                    state    <= WRITE;
                    tw_start <= 1'b1;
                end
                WRITE:      state <= WRITE_WAIT;
                WRITE_WAIT: if (tw_done) state <= NEXT;
                NEXT: if (tx < X_LAST) begin
                    tx        <= tx + 16'd1;
                    tile_px   <= (tx + 16'd1) << TILE_SHIFT;
                    state     <= CLEAR;
                    clr_start <= 1'b1;
                end else if (ty < Y_LAST) begin
                    tx        <= '0;
                    ty        <= ty + 16'd1;
                    tile_px   <= '0;
                    tile_py   <= (ty + 16'd1) << TILE_SHIFT;
                    state     <= CLEAR;
                    clr_start <= 1'b1;
                end else begin
                    tx      <= '0;
                    tile_px <= '0;
`ifdef TILE_SCHED_DBUF_EN
                    state <= FLIP_WAIT;
`else
                    state      <= DONE;
                    frame_done <= 1'b1;
`endif
                end
`ifdef TILE_SCHED_DBUF_EN
                FLIP_WAIT: if (vblank) begin
                    buf_sel      <= ~buf_sel;
                    tw_fb_base   <= buf_sel ? fb_base_b : fb_base_a;
                    disp_fb_base <= buf_sel ? fb_base_a : fb_base_b;
                    state        <= DONE;
                    frame_done   <= 1'b1;
                end
`endif
                default: begin
                    state      <= IDLE;
                    frame_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
